timer_countdown: RTL and testbench

//  Receiving end of the timer_controler keypad encoder in the microwave datapath.

---
 rtl/timer_countdown.sv | 136 +++++++++++++
 tb/tb_timer_countdown.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_countdown.sv
// Four-digit MM:SS countdown register for the microwave datapath: shifts in
// keypad BCD digits, counts down on 1 Hz ticks while enabled, flags zero/done.
module timer_countdown #(
  parameter logic [3:0] SEC_TENS_MAX = 4'd5,
  parameter logic [3:0] SEC_ONES_MAX = 4'd9
) (
  input  logic       clk_100Hz,
  input  logic       clearn,
  input  logic [0:3] bcd,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       enablen,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       loadn_q, pgt_q;
  logic       done_q, done_d;
  logic       load_ev, tick_ev, load_ok, dec_zero;

  assign load_ev = loadn_q & ~loadn;
  assign tick_ev = ~pgt_q & pgt_1Hz;
  assign load_ok = load_ev & (bcd <= 4'd9);

  // Borrow chain; seconds above 59 simply count down until the minute borrow.
  always_comb begin
    dec_mt = mt_q;
    dec_mo = mo_q;
    dec_st = st_q;
    dec_so = so_q;
    if (so_q != 4'd0) begin
      dec_so = so_q - 4'd1;
    end else begin
      dec_so = SEC_ONES_MAX;
      if (st_q != 4'd0) begin
        dec_st = st_q - 4'd1;
      end else begin
        dec_st = SEC_TENS_MAX;
        if (mo_q != 4'd0) begin
          dec_mo = mo_q - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = mt_q - 4'd1;
        end
      end
    end
  end

  assign dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == '0);

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_ok) begin
          mt_d = mo_q;
          mo_d = st_q;
          st_d = so_q;
          so_d = bcd;
        end
        if (!enablen && !zero) state_d = RUN;
      end
      RUN: begin
        if (enablen) begin
          state_d = IDLE;
        end else if (tick_ev) begin
          mt_d = dec_mt;
          mo_d = dec_mo;
          st_d = dec_st;
          so_d = dec_so;
          if (dec_zero) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        if (load_ok) begin
          mt_d    = mo_q;
          mo_d    = st_q;
          st_d    = so_q;
          so_d    = bcd;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100Hz or negedge clearn) begin
    if (!clearn) begin
      state_q <= IDLE;
      mt_q    <= '0;
      mo_q    <= '0;
      st_q    <= '0;
      so_q    <= '0;
      loadn_q <= 1'b1;
      pgt_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
      loadn_q <= loadn;
      pgt_q   <= pgt_1Hz;
      done_q  <= done_d;
    end
  end

  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign zero     = ({mt_q, mo_q, st_q, so_q} == '0);
  assign running  = (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_timer_countdown.sv
// Self-checking bench for timer_countdown: vector table plus hand-written
// sequences for simultaneous events and mid-count reset.
module tb_timer_countdown;

  logic       clk_100Hz = 1'b0;
  logic       clearn;
  logic [0:3] bcd;
  logic       loadn, pgt_1Hz, enablen;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       zero, running, done;

  timer_countdown #(.SEC_TENS_MAX(4'd5), .SEC_ONES_MAX(4'd9)) dut (
    .clk_100Hz(clk_100Hz), .clearn(clearn), .bcd(bcd), .loadn(loadn),
    .pgt_1Hz(pgt_1Hz), .enablen(enablen),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .zero(zero), .running(running), .done(done)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  typedef enum logic [1:0] {OP_RST, OP_KEY, OP_TICK, OP_EN} op_t;
  typedef struct {
    op_t         op;
    logic [3:0]  arg;
    logic [15:0] digits;
    logic        run;
    logic        zr;
    int unsigned dones;
  } vec_t;
  typedef struct {
    logic [15:0] digits;
    logic        run;
    logic        zr;
    int unsigned dones;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int unsigned checks = 0, failures = 0;
  int unsigned done_cnt = 0, done_mark = 0;

  always @(negedge clk_100Hz) if (done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk_100Hz);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    bcd = d;
    loadn = 1'b0;
    repeat (3) step();
    loadn = 1'b1;
    repeat (2) step();
  endtask

  task automatic tick();
    pgt_1Hz = 1'b1;
    repeat (2) step();
    pgt_1Hz = 1'b0;
    repeat (2) step();
  endtask

  task automatic set_en(input logic v);
    enablen = v;
    repeat (2) step();
  endtask

  task automatic do_rst();
    enablen = 1'b1;
    loadn   = 1'b1;
    pgt_1Hz = 1'b0;
    clearn  = 1'b0;
    step();
    clearn  = 1'b1;
    step();
  endtask

  task automatic expect_out(input logic [15:0] d, input logic r, input logic z, input int unsigned n);
    exp_t e;
    e.digits = d;
    e.run    = r;
    e.zr     = z;
    e.dones  = n;
    sb.push_back(e);
  endtask

  task automatic check_out(input string name);
    exp_t        e;
    logic [15:0] got;
    int unsigned nd;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e   = sb.pop_front();
    got = {min_tens, min_ones, sec_tens, sec_ones};
    nd  = done_cnt - done_mark;
    done_mark = done_cnt;
    if (got !== e.digits) begin
      failures++;
      $display("FAIL %s digits got=%h exp=%h", name, got, e.digits);
    end
    checks++;
    if (running !== e.run) begin
      failures++;
      $display("FAIL %s running got=%b exp=%b", name, running, e.run);
    end
    checks++;
    if (zero !== e.zr) begin
      failures++;
      $display("FAIL %s zero got=%b exp=%b", name, zero, e.zr);
    end
    checks++;
    if (nd != e.dones) begin
      failures++;
      $display("FAIL %s done_pulses got=%0d exp=%0d", name, nd, e.dones);
    end
  endtask

  function automatic void add(input op_t op, input logic [3:0] a, input logic [15:0] d,
                              input logic r, input logic z, input int unsigned n);
    vec_t v;
    v.op = op; v.arg = a; v.digits = d; v.run = r; v.zr = z; v.dones = n;
    vecs.push_back(v);
  endfunction

  initial begin
    clearn = 1'b0; loadn = 1'b1; pgt_1Hz = 1'b0; enablen = 1'b1; bcd = 4'd0;
    repeat (2) step();
    clearn = 1'b1;
    step();

    add(OP_RST,  0, 16'h0000, 0, 1, 0);
    add(OP_KEY,  1, 16'h0001, 0, 0, 0);
    add(OP_KEY,  2, 16'h0012, 0, 0, 0);
    add(OP_KEY,  3, 16'h0123, 0, 0, 0);
    add(OP_KEY, 15, 16'h0123, 0, 0, 0);
    add(OP_RST,  0, 16'h0000, 0, 1, 0);
    add(OP_KEY,  0, 16'h0000, 0, 1, 0);
    add(OP_KEY,  0, 16'h0000, 0, 1, 0);
    add(OP_KEY,  0, 16'h0000, 0, 1, 0);
    add(OP_KEY,  2, 16'h0002, 0, 0, 0);
    add(OP_EN,   0, 16'h0002, 1, 0, 0);
    add(OP_TICK, 0, 16'h0001, 1, 0, 0);
    add(OP_TICK, 0, 16'h0000, 0, 1, 1);
    add(OP_TICK, 0, 16'h0000, 0, 1, 0);
    add(OP_EN,   1, 16'h0000, 0, 1, 0);
    add(OP_KEY,  1, 16'h0001, 0, 0, 0);
    add(OP_EN,   0, 16'h0001, 1, 0, 0);
    add(OP_EN,   1, 16'h0001, 0, 0, 0);
    add(OP_RST,  0, 16'h0000, 0, 1, 0);
    add(OP_KEY,  1, 16'h0001, 0, 0, 0);
    add(OP_KEY,  0, 16'h0010, 0, 0, 0);
    add(OP_KEY,  0, 16'h0100, 0, 0, 0);
    add(OP_EN,   0, 16'h0100, 1, 0, 0);
    add(OP_TICK, 0, 16'h0059, 1, 0, 0);
    add(OP_EN,   1, 16'h0059, 0, 0, 0);
    add(OP_RST,  0, 16'h0000, 0, 1, 0);
    add(OP_KEY,  1, 16'h0001, 0, 0, 0);
    add(OP_KEY,  0, 16'h0010, 0, 0, 0);
    add(OP_KEY,  0, 16'h0100, 0, 0, 0);
    add(OP_KEY,  0, 16'h1000, 0, 0, 0);
    add(OP_EN,   0, 16'h1000, 1, 0, 0);
    add(OP_TICK, 0, 16'h0959, 1, 0, 0);
    add(OP_KEY,  7, 16'h0959, 1, 0, 0);
    add(OP_TICK, 0, 16'h0958, 1, 0, 0);
    add(OP_EN,   1, 16'h0958, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(OP_TICK, 0, 16'h0958, 0, 0, 0);
    add(OP_EN,   0, 16'h0958, 1, 0, 0);
    add(OP_TICK, 0, 16'h0957, 1, 0, 0);
    add(OP_RST,  0, 16'h0000, 0, 1, 0);
    add(OP_KEY,  9, 16'h0009, 0, 0, 0);
    add(OP_KEY,  9, 16'h0099, 0, 0, 0);
    add(OP_EN,   0, 16'h0099, 1, 0, 0);
    add(OP_TICK, 0, 16'h0098, 1, 0, 0);
    add(OP_EN,   1, 16'h0098, 0, 0, 0);

    done_mark = done_cnt;
    for (int i = 0; i < vecs.size(); i++) begin
      unique case (vecs[i].op)
        OP_RST:  do_rst();
        OP_KEY:  key(vecs[i].arg);
        OP_TICK: tick();
        OP_EN:   set_en(vecs[i].arg[0]);
        default: ;
      endcase
      expect_out(vecs[i].digits, vecs[i].run, vecs[i].zr, vecs[i].dones);
      check_out($sformatf("vec%0d", i));
    end

    // Start and tick land on the same edge: only the transition happens.
    do_rst();
    key(4'd0); key(4'd0); key(4'd0); key(4'd3);
    enablen = 1'b0;
    pgt_1Hz = 1'b1;
    repeat (2) step();
    pgt_1Hz = 1'b0;
    repeat (2) step();
    expect_out(16'h0003, 1, 0, 0);
    check_out("start_with_tick");
    tick();
    expect_out(16'h0002, 1, 0, 0);
    check_out("first_tick_after_start");

    enablen = 1'b1;
    pgt_1Hz = 1'b1;
    repeat (2) step();
    pgt_1Hz = 1'b0;
    repeat (2) step();
    expect_out(16'h0002, 0, 0, 0);
    check_out("pause_with_tick");
    set_en(1'b0);
    tick();
    expect_out(16'h0001, 1, 0, 0);
    check_out("resume_after_pause");

    clearn = 1'b0;
    step();
    clearn = 1'b1;
    repeat (2) step();
    expect_out(16'h0000, 0, 1, 0);
    check_out("reset_mid_count");
    tick();
    expect_out(16'h0000, 0, 1, 0);
    check_out("zero_stays_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
